// File: rtl/mavg_pkg.sv
// Shared constants and width helper for the moving-average block.
package mavg_pkg;

  localparam int unsigned DEF_W     = 4;
  localparam int unsigned DEF_LOG2N = 2;

  function automatic int unsigned sum_width(input int unsigned w, input int unsigned log2n);
    return w + log2n;
  endfunction

endpackage

// File: rtl/mavg_param_if.sv
// Sample-stream bundle for mavg_param: producer drives samples/clear, consumer returns averages.
interface mavg_param_if
  import mavg_pkg::*;
#(
  parameter int unsigned W = DEF_W
);
  logic         clear;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         full;

  modport master (
    output clear, in_valid, x,
    input  y, out_valid, full
  );

  modport slave (
    input  clear, in_valid, x,
    output y, out_valid, full
  );
endinterface

// File: rtl/mavg_ring.sv
// N-deep sample ring with wrapping write pointer; o_oldest is the slot about to be overwritten.
module mavg_ring
  import mavg_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LOG2N = DEF_LOG2N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_wr,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_oldest
);
  localparam int unsigned N = 1 << LOG2N;

  logic [W-1:0]     r_mem [N];
  logic [LOG2N-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (i_clear) begin
      for (int unsigned i = 0; i < N; i++) r_mem[i] <= '0;
      r_ptr <= '0;
    end else if (i_wr) begin
      r_mem[r_ptr] <= i_data;
      // N is a power of two, so natural overflow gives the N-1 -> 0 wrap
      r_ptr        <= r_ptr + 1'b1;
    end
  end

  assign o_oldest = r_mem[r_ptr];

endmodule

// File: rtl/mavg_param.sv
// Windowed moving average over the last 2**LOG2N samples, one-cycle latency.
// Optional macro MAVG_ROUND_EN selects round-half-up instead of truncation.
module mavg_param
  import mavg_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned LOG2N = DEF_LOG2N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         out_valid,
  output logic         full
);
  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned SW = sum_width(W, LOG2N);

  logic [SW-1:0]  r_sum;
  logic [SW-1:0]  w_sum_next;
  logic [W-1:0]   w_oldest;
  logic [W-1:0]   w_avg;
  logic [W-1:0]   r_y;
  logic           r_out_valid;
  logic [LOG2N:0] r_fill;
  logic           w_full;

  mavg_ring #(
    .W     (W),
    .LOG2N (LOG2N)
  ) u_ring (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (clear),
    .i_wr     (in_valid),
    .i_data   (x),
    .o_oldest (w_oldest)
  );

  // Empty slots read as zero, so the running sum needs no fill-dependent correction
  assign w_sum_next = r_sum + SW'(x) - SW'(w_oldest);

`ifdef MAVG_ROUND_EN
  assign w_avg = W'((w_sum_next + SW'(N / 2)) >> LOG2N);
`else
  assign w_avg = W'(w_sum_next >> LOG2N);
`endif

  assign w_full = (r_fill == (LOG2N + 1)'(N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_fill      <= '0;
    end else if (clear) begin
      r_sum       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_fill      <= '0;
    end else if (in_valid) begin
      r_sum       <= w_sum_next;
      r_y         <= w_avg;
      r_out_valid <= 1'b1;
      if (!w_full) r_fill <= r_fill + 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign full      = w_full;

endmodule

// File: tb/tb_mavg_param.sv
// Self-checking bench for mavg_param: directed scenarios plus random traffic vs. a queue model.
module tb_mavg_param;
  localparam int unsigned W     = 4;
  localparam int unsigned LOG2N = 2;
  localparam int unsigned N     = 1 << LOG2N;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  mavg_param_if #(.W(W)) bus ();

  mavg_param #(
    .W     (W),
    .LOG2N (LOG2N)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .clear     (bus.clear),
    .in_valid  (bus.in_valid),
    .x         (bus.x),
    .y         (bus.y),
    .out_valid (bus.out_valid),
    .full      (bus.full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned q[$];
  int unsigned m_y;
  int unsigned m_ov;
  int unsigned m_fill;

  function automatic int unsigned avg(input int unsigned s);
`ifdef MAVG_ROUND_EN
    return (s + N / 2) / N;
`else
    return s / N;
`endif
  endfunction

  function automatic int unsigned qsum();
    int unsigned s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < int'(N); i++) q.push_back(0);
    m_y = 0; m_ov = 0; m_fill = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"},         32'(bus.y),         m_y);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), m_ov);
    chk({tag, ".full"},      32'(bus.full),      (m_fill == N) ? 1 : 0);
  endtask

  task automatic step(input string tag, input bit v, input logic [W-1:0] xv, input bit clr);
    @(negedge clk);
    bus.in_valid = v; bus.x = xv; bus.clear = clr;
    @(posedge clk);
    #1;
    if (clr) model_reset();
    else if (v) begin
      q.push_back(int'(xv));
      void'(q.pop_front());
      m_y  = avg(qsum());
      m_ov = 1;
      if (m_fill < N) m_fill++;
    end else m_ov = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0; bus.x = '0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int unsigned rise[4];
  int unsigned fall[4];

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.x = '0;
`ifdef MAVG_ROUND_EN
    rise = '{4, 8, 11, 15}; fall = '{11, 8, 4, 0};
`else
    rise = '{3, 7, 11, 15}; fall = '{11, 7, 3, 0};
`endif
    do_reset();

    // ramp up then down with literal expectations
    for (int i = 0; i < 4; i++) begin
      step("rise", 1'b1, 4'hF, 1'b0);
      chk("rise.lit", 32'(bus.y), rise[i]);
    end
    chk("rise.full", 32'(bus.full), 1);
    for (int i = 0; i < 4; i++) begin
      step("fall", 1'b1, 4'h0, 1'b0);
      chk("fall.lit", 32'(bus.y), fall[i]);
    end

    // gated valid and pointer wrap
    do_reset();
    step("gate1", 1'b1, 4'hF, 1'b0);
    step("gate0", 1'b0, 4'hF, 1'b0);
    chk("gate0.hold", 32'(bus.y), rise[0]);
    step("gate1b", 1'b1, 4'hF, 1'b0);
    chk("gate1b.lit", 32'(bus.y), rise[1]);
    for (int i = 0; i < 5; i++) step("wrap", 1'b1, 4'hF, 1'b0);
    chk("wrap.lit", 32'(bus.y), 15);

    // clear beats simultaneous valid
    step("clr", 1'b1, 4'hF, 1'b1);
    chk("clr.y", 32'(bus.y), 0);
    step("postclr", 1'b1, 4'hF, 1'b0);
    chk("postclr.lit", 32'(bus.y), rise[0]);

    // asynchronous reset mid-window
    do_reset();
    for (int i = 0; i < 3; i++) step("pre_arst", 1'b1, 4'hF, 1'b0);
    step("pre_arst_idle", 1'b0, 4'h0, 1'b0);
    chk("pre_arst.lit", 32'(bus.y), 11);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst", 1'b1, 4'h8, 1'b0);
    chk("post_arst.lit", 32'(bus.y), 2);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) < 8), W'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mavg_param.md
MAVG_PARAM -- requirements
Module: mavg_param

Interface
REQ-001 Parameter W, default 4: sample width in bits, 2..16.
REQ-002 Parameter LOG2N, default 2: window depth N = 2**LOG2N, LOG2N 1..6.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port clear, input, 1: synchronous flush of window state.
REQ-006 Port in_valid, input, 1: x carries a sample this cycle.
REQ-007 Port x, input, W: unsigned sample.
REQ-008 Port y, output, W: unsigned window average, registered.
REQ-009 Port out_valid, output, 1: y updated this cycle.
REQ-010 Port full, output, 1: at least N samples accepted since reset or clear.

Function
REQ-011 The block SHALL hold the last N samples in a ring (N x W registers), a write pointer of LOG2N bits, and a running sum S of W+LOG2N bits.
REQ-012 On an edge with in_valid=1 and clear=0, the block SHALL update S <= S + x - ring[ptr], write ring[ptr] <= x, and advance ptr, wrapping N-1 -> 0.
REQ-013 On that same edge, y SHALL load the truncated average (S_next >> LOG2N) and out_valid SHALL go 1: latency is one clock from sample to average.
REQ-014 On any edge with in_valid=0, S, ring, ptr and y SHALL hold, and out_valid SHALL be 0.
REQ-015 Fill count SHALL increment per accepted sample and saturate at N; full = (fill count == N).
REQ-016 Before full, empty slots SHALL count as zero: y = (sum of accepted samples) >> LOG2N, not divided by fill count.
REQ-017 S SHALL never overflow: N*(2**W-1) fits in W+LOG2N bits. Arithmetic is unsigned throughout.
REQ-018 clear=1 SHALL zero ring, S, ptr, fill count and y, and force out_valid=0 on that edge; clear wins over a simultaneous in_valid, and that sample is dropped.
REQ-019 Back-to-back in_valid every cycle SHALL be sustained with no bubbles.

Reset
REQ-020 reset=0 SHALL asynchronously force ring, S, ptr, fill count, y, out_valid and full to 0, including mid-window.
REQ-021 The first sample after reset release SHALL be processed as if following clear.

Configuration
REQ-022 With macro MAVG_ROUND_EN defined, y SHALL be (S_next + 2**(LOG2N-1)) >> LOG2N, round-half-up. This cannot exceed 2**W-1, so no saturation logic is needed.
REQ-023 Without MAVG_ROUND_EN, y SHALL be the truncated S_next >> LOG2N; all other behaviour is identical.

Structure
REQ-024 Package mavg_pkg SHALL hold the default W/LOG2N constants and a function for the sum width (W+LOG2N).
REQ-025 Ring storage and pointer SHALL be the sub-module mavg_ring (write, read-oldest, clear); sum, fill count and output registers live in mavg_param.

Verification
REQ-026 W=4, LOG2N=2, truncating; reset, then x=0xF valid for 4 cycles -> y = 3, 7, 11, 15, each with out_valid=1; full=1 after the 4th.
REQ-027 Continue from REQ-026 with x=0x0 valid for 4 cycles -> y = 11, 7, 3, 0.
REQ-028 Same sequences with MAVG_ROUND_EN -> rise 4, 8, 11, 15; fall 11, 8, 4, 0.
REQ-029 in_valid gated 1-0-1 with x=0xF from reset -> y = 3, holds 3 with out_valid=0, then 7; ptr wraps correctly after 5 accepted samples (y stays 15 at steady state).
REQ-030 After full at 15, assert clear together with in_valid, x=0xF -> y=0, full=0, out_valid=0; the next valid 0xF -> y=3.
REQ-031 Assert reset mid-window (y=11), asynchronously between edges -> all outputs 0 immediately; after release, x=0x8 once -> y=2.
